// File: rtl/axi_logger_pkg.sv
// Shared types and helpers for the multi-channel AXI BRAM logger.
package axi_logger_pkg;

  // Logging policy once the buffer has been filled.
  typedef enum logic {
    MODE_STOP = 1'b0,
    MODE_RING = 1'b1
  } mode_e;

  // Width of the channel-index field; a single channel still gets one bit.
  function automatic int CH_BITW(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Default configuration of the logger.
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_ADDR_BITW = 32;
  localparam int DEF_ID_BITW   = 8;
  localparam int DEF_LEN_BITW  = 8;
  localparam int DEF_TS_BITW   = 32;
  localparam int DEF_CH_BITW   = CH_BITW(DEF_NUM_CH);

  // Entry layout for the default configuration, MSB first; software decodes
  // RdData_DO with this. The top mirrors the field order for its own widths.
  typedef struct packed {
    logic [DEF_TS_BITW-1:0]   ts;
    logic [DEF_CH_BITW-1:0]   ch;
    logic [DEF_ID_BITW-1:0]   id;
    logic [DEF_LEN_BITW-1:0]  len;
    logic [DEF_ADDR_BITW-1:0] addr;
  } log_entry_t;

endpackage

// File: rtl/logger_rr_arb.sv
// Round-robin arbiter choosing one pending channel per cycle.
module logger_rr_arb
  import axi_logger_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_BITW = CH_BITW(NUM_CH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [NUM_CH-1:0]   req_i,
  input  logic                advance_i,
  output logic [NUM_CH-1:0]   grant_oh_o,
  output logic [IDX_BITW-1:0] grant_idx_o,
  output logic                grant_vld_o
);

  logic [IDX_BITW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_BITW:0]   cand;
  logic [IDX_BITW:0]   nxt;

  // Scan requests starting at the round-robin pointer, first hit wins.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_BITW+1)'(i);
      if (cand >= (IDX_BITW+1)'(NUM_CH)) begin
        cand = cand - (IDX_BITW+1)'(NUM_CH);
      end
      if (!grant_vld_o && req_i[cand[IDX_BITW-1:0]]) begin
        grant_vld_o = 1'b1;
        grant_oh_o[cand[IDX_BITW-1:0]] = 1'b1;
        grant_idx_o = cand[IDX_BITW-1:0];
      end
    end
  end

  // Pointer moves past the winner only when its entry was actually written.
  always_comb begin
    nxt = {1'b0, grant_idx_o} + (IDX_BITW+1)'(1);
    if (nxt >= (IDX_BITW+1)'(NUM_CH)) begin
      nxt = '0;
    end
    rr_ptr_d = rr_ptr_q;
    if (clr_i) begin
      rr_ptr_d = '0;
    end else if (advance_i) begin
      rr_ptr_d = nxt[IDX_BITW-1:0];
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/axi_bram_logger_mc.sv
// Multi-channel AXI address-channel logger writing timestamped entries to BRAM.
module axi_bram_logger_mc
  import axi_logger_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int AXI_ADDR_BITW  = 32,
  parameter int AXI_ID_BITW    = 8,
  parameter int AXI_LEN_BITW   = 8,
  parameter int TIMESTAMP_BITW = 32,
  parameter int DEPTH          = 4096,
  parameter int DROP_CNT_BITW  = 16,
  localparam int CHW        = CH_BITW(NUM_CH),
  localparam int PTR_BITW   = $clog2(DEPTH),
  localparam int CNT_BITW   = PTR_BITW + 1,
  localparam int ENTRY_BITW = TIMESTAMP_BITW + CHW + AXI_ID_BITW + AXI_LEN_BITW + AXI_ADDR_BITW
) (
  input  logic                             Clk_CI,
  input  logic                             Rst_RBI,
  input  logic [NUM_CH-1:0]                AxiValid_SI,
  input  logic [NUM_CH*AXI_ID_BITW-1:0]    AxiId_DI,
  input  logic [NUM_CH*AXI_ADDR_BITW-1:0]  AxiAddr_DI,
  input  logic [NUM_CH*AXI_LEN_BITW-1:0]   AxiLen_DI,
  input  logic                             Enable_SI,
  input  logic                             Clear_SI,
  input  logic                             RingMode_SI,
  output logic                             Full_SO,
  output logic                             Wrapped_SO,
  output logic [CNT_BITW-1:0]              LogCnt_DO,
  output logic [PTR_BITW-1:0]              WrPtr_DO,
  output logic [DROP_CNT_BITW-1:0]         DropCnt_DO,
  input  logic [PTR_BITW-1:0]              RdAddr_DI,
  output logic [ENTRY_BITW-1:0]            RdData_DO
);

  typedef struct packed {
    logic [TIMESTAMP_BITW-1:0] ts;
    logic [CHW-1:0]            ch;
    logic [AXI_ID_BITW-1:0]    id;
    logic [AXI_LEN_BITW-1:0]   len;
    logic [AXI_ADDR_BITW-1:0]  addr;
  } entry_t;

  logic [TIMESTAMP_BITW-1:0] ts_q, ts_d;
  logic [NUM_CH-1:0]         pend_vld_q, pend_vld_d;
  entry_t                    pend_q [NUM_CH];
  entry_t                    pend_d [NUM_CH];
  logic [PTR_BITW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_BITW-1:0]       log_cnt_q, log_cnt_d;
  logic                      wrapped_q, wrapped_d;
  logic [DROP_CNT_BITW-1:0]  drop_cnt_q, drop_cnt_d;
  mode_e                     mode_q, mode_d;
  logic [ENTRY_BITW-1:0]     rd_data_q;
  logic [ENTRY_BITW-1:0]     mem [DEPTH];

  logic [NUM_CH-1:0]         grant_oh;
  logic [CHW-1:0]            grant_idx;
  logic                      grant_vld;
  logic                      do_write;
  logic                      log_full;
  logic [NUM_CH-1:0]         granted;
  logic                      ev, slot_free;
  logic [3:0]                drop_inc;
  logic [DROP_CNT_BITW+3:0]  drop_sum;
  entry_t                    wr_entry;

  logger_rr_arb #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk_i       (Clk_CI),
    .rst_ni      (Rst_RBI),
    .clr_i       (Clear_SI),
    .req_i       (pend_vld_q),
    .advance_i   (do_write),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  // Next-state for timestamp, pending slots, write pointer, counters and mode.
  always_comb begin
    ts_d       = ts_q + TIMESTAMP_BITW'(1);
    pend_vld_d = pend_vld_q;
    wr_ptr_d   = wr_ptr_q;
    log_cnt_d  = log_cnt_q;
    wrapped_d  = wrapped_q;
    mode_d     = mode_q;
    drop_inc   = '0;
    ev         = 1'b0;
    slot_free  = 1'b0;
    log_full   = (log_cnt_q == CNT_BITW'(DEPTH));
    do_write   = grant_vld && !(mode_q == MODE_STOP && log_full) && !Clear_SI && Rst_RBI;
    granted    = do_write ? grant_oh : '0;
    wr_entry   = pend_q[grant_idx];

    for (int c = 0; c < NUM_CH; c++) begin
      pend_d[c] = pend_q[c];
      ev        = AxiValid_SI[c] && Enable_SI && !Clear_SI;
      slot_free = !pend_vld_q[c] || granted[c];
      if (granted[c]) begin
        pend_vld_d[c] = 1'b0;
      end
      if (ev && slot_free) begin
        pend_vld_d[c] = 1'b1;
        pend_d[c] = '{ts:   ts_q,
                      ch:   CHW'(c),
                      id:   AxiId_DI[c*AXI_ID_BITW +: AXI_ID_BITW],
                      len:  AxiLen_DI[c*AXI_LEN_BITW +: AXI_LEN_BITW],
                      addr: AxiAddr_DI[c*AXI_ADDR_BITW +: AXI_ADDR_BITW]};
      end
      drop_inc = drop_inc + 4'(ev && !slot_free);
    end

    drop_sum = {4'b0, drop_cnt_q} + {(DROP_CNT_BITW)'(0), drop_inc};
    if (drop_sum > {4'b0, {DROP_CNT_BITW{1'b1}}}) begin
      drop_cnt_d = '1;
    end else begin
      drop_cnt_d = drop_sum[DROP_CNT_BITW-1:0];
    end

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PTR_BITW'(1);
      if (!log_full) begin
        log_cnt_d = log_cnt_q + CNT_BITW'(1);
      end
      if (mode_q == MODE_RING && wr_ptr_q == PTR_BITW'(DEPTH - 1)) begin
        wrapped_d = 1'b1;
      end
    end

    if (Clear_SI) begin
      ts_d       = '0;
      pend_vld_d = '0;
      wr_ptr_d   = '0;
      log_cnt_d  = '0;
      wrapped_d  = 1'b0;
      drop_cnt_d = '0;
      mode_d     = mode_e'(RingMode_SI);
    end
  end

  // Control state registers; reset behaves like a clear and resamples the mode.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      ts_q       <= '0;
      pend_vld_q <= '0;
      wr_ptr_q   <= '0;
      log_cnt_q  <= '0;
      wrapped_q  <= 1'b0;
      drop_cnt_q <= '0;
      mode_q     <= mode_e'(RingMode_SI);
    end else begin
      ts_q       <= ts_d;
      pend_vld_q <= pend_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      log_cnt_q  <= log_cnt_d;
      wrapped_q  <= wrapped_d;
      drop_cnt_q <= drop_cnt_d;
      mode_q     <= mode_d;
    end
  end

  // Pending payloads need no reset; they are only consumed while their valid is set.
  always_ff @(posedge Clk_CI) begin
    for (int c = 0; c < NUM_CH; c++) begin
      pend_q[c] <= pend_d[c];
    end
  end

  // Simple dual-port RAM, read-first on collision, registered read data.
  always_ff @(posedge Clk_CI) begin
    if (do_write) begin
      mem[wr_ptr_q] <= wr_entry;
    end
    if (!Rst_RBI) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[RdAddr_DI];
    end
  end

  assign Full_SO    = (mode_q == MODE_STOP) ? log_full : wrapped_q;
  assign Wrapped_SO = wrapped_q;
  assign LogCnt_DO  = log_cnt_q;
  assign WrPtr_DO   = wr_ptr_q;
  assign DropCnt_DO = drop_cnt_q;
  assign RdData_DO  = rd_data_q;

endmodule

// File: tb/tb_axi_bram_logger_mc.sv
// Self-checking bench for axi_bram_logger_mc with a small-depth buffer.
module tb_axi_bram_logger_mc;
  import axi_logger_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid;
  logic [15:0] id_in;
  logic [63:0] addr_in;
  logic [15:0] len_in;
  logic        en, clr, ring;
  logic [3:0]  rd_addr;
  logic        full, wrapped;
  logic [4:0]  log_cnt;
  logic [3:0]  wr_ptr;
  logic [15:0] drop_cnt;
  logic [80:0] rd_data;

  int checks = 0;
  int passes = 0;

  axi_bram_logger_mc #(
    .NUM_CH(NCH),
    .DEPTH(DEPTH)
  ) dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .AxiValid_SI (valid),
    .AxiId_DI    (id_in),
    .AxiAddr_DI  (addr_in),
    .AxiLen_DI   (len_in),
    .Enable_SI   (en),
    .Clear_SI    (clr),
    .RingMode_SI (ring),
    .Full_SO     (full),
    .Wrapped_SO  (wrapped),
    .LogCnt_DO   (log_cnt),
    .WrPtr_DO    (wr_ptr),
    .DropCnt_DO  (drop_cnt),
    .RdAddr_DI   (rd_addr),
    .RdData_DO   (rd_data)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Reference model: buffer contents as an array, pending slots as one-deep queues.
  log_entry_t  m_mem [DEPTH];
  bit          m_known [DEPTH];
  log_entry_t  m_pe [NCH];
  bit          m_pv [NCH];
  logic [31:0] m_ts;
  int          m_rr, m_wp, m_cnt, m_drop, m_g;
  bit          m_wrapped, m_ring, m_started = 1'b0;
  log_entry_t  m_rd;
  bit          m_rd_known;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rd = '0;
      m_rd_known = 1'b1;
      for (int a = 0; a < DEPTH; a++) m_known[a] = 1'b0;
    end else begin
      m_rd = m_mem[rd_addr];
      m_rd_known = m_known[rd_addr];
    end
    if (!rst_n || clr) begin
      m_ts = '0; m_rr = 0; m_wp = 0; m_cnt = 0; m_drop = 0;
      m_wrapped = 1'b0; m_ring = ring; m_started = 1'b1;
      for (int c = 0; c < NCH; c++) m_pv[c] = 1'b0;
    end else begin
      m_g = -1;
      for (int k = 0; k < NCH; k++) begin
        if (m_g < 0 && m_pv[(m_rr + k) % NCH]) m_g = (m_rr + k) % NCH;
      end
      if (m_g >= 0 && (m_ring || m_cnt < DEPTH)) begin
        m_mem[m_wp] = m_pe[m_g];
        m_known[m_wp] = 1'b1;
        m_wp = m_wp + 1;
        if (m_wp == DEPTH) begin
          m_wp = 0;
          if (m_ring) m_wrapped = 1'b1;
        end
        if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
        m_rr = (m_g + 1) % NCH;
        m_pv[m_g] = 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (valid[c] && en) begin
          if (!m_pv[c]) begin
            m_pv[c] = 1'b1;
            m_pe[c] = '{ts: m_ts, ch: 1'(c), id: id_in[c*8 +: 8],
                        len: len_in[c*8 +: 8], addr: addr_in[c*32 +: 32]};
          end else if (m_drop < 65535) begin
            m_drop = m_drop + 1;
          end
        end
      end
      m_ts = m_ts + 32'd1;
    end
  end

  // Continuous comparison of every observable output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      checkOutput("log_cnt", 128'(log_cnt), 128'(m_cnt));
      checkOutput("wr_ptr", 128'(wr_ptr), 128'(m_wp));
      checkOutput("drop_cnt", 128'(drop_cnt), 128'(m_drop));
      checkOutput("wrapped", 128'(wrapped), 128'(m_wrapped));
      checkOutput("full", 128'(full), 128'(m_ring ? m_wrapped : (m_cnt == DEPTH)));
      if (m_rd_known) checkOutput("rd_data", 128'(rd_data), 128'(m_rd));
    end
  end

  // Drive one cycle of channel traffic; ch1 uses addr+4 and len+1.
  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] i1,
                               input logic [31:0] a0, input logic [7:0] l0);
    valid   = v;
    id_in   = {i1, i0};
    addr_in = {a0 + 32'd4, a0};
    len_in  = {l0 + 8'd1, l0};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic doClear(input logic r);
    valid = '0;
    clr   = 1'b1;
    ring  = r;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  task automatic readEntry(input logic [3:0] a, output logic [80:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  logic [80:0] rd;
  logic [80:0] exp_tab [4];
  log_entry_t  ent;

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; ring = 1'b0; valid = '0;
    id_in = '0; addr_in = '0; len_in = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_log_cnt", 128'(log_cnt), 128'd0);
    checkOutput("reset_drop", 128'(drop_cnt), 128'd0);
    checkOutput("reset_rd_data", 128'(rd_data), 128'd0);
    rst_n = 1'b1;

    $display("[TB] single event at timestamp 5");
    repeat (5) @(negedge clk);
    applyStimulus(2'b01, 8'h3A, 8'h00, 32'h1000_0040, 8'd7);
    idle(1);
    checkOutput("single_log_cnt", 128'(log_cnt), 128'd1);
    checkOutput("single_wr_ptr", 128'(wr_ptr), 128'd1);
    readEntry(4'd0, rd);
    checkOutput("single_entry", 128'(rd), 128'({32'd5, 1'b0, 8'h3A, 8'd7, 32'h1000_0040}));

    $display("[TB] simultaneous traffic on both channels");
    doClear(1'b0);
    applyStimulus(2'b11, 8'h10, 8'h20, 32'h2000_0000, 8'd4);
    applyStimulus(2'b11, 8'h11, 8'h21, 32'h2000_0000, 8'd4);
    applyStimulus(2'b11, 8'h12, 8'h22, 32'h2000_0000, 8'd4);
    idle(4);
    checkOutput("simul_drop", 128'(drop_cnt), 128'd2);
    checkOutput("simul_log_cnt", 128'(log_cnt), 128'd4);
    exp_tab[0] = {32'd0, 1'b0, 8'h10, 8'd4, 32'h2000_0000};
    exp_tab[1] = {32'd0, 1'b1, 8'h20, 8'd5, 32'h2000_0004};
    exp_tab[2] = {32'd1, 1'b0, 8'h11, 8'd4, 32'h2000_0000};
    exp_tab[3] = {32'd2, 1'b1, 8'h22, 8'd5, 32'h2000_0004};
    for (int a = 0; a < 4; a++) begin
      readEntry(4'(a), rd);
      checkOutput($sformatf("simul_entry%0d", a), 128'(rd), 128'(exp_tab[a]));
    end

    $display("[TB] clear coincident with event and pending write");
    applyStimulus(2'b10, 8'h00, 8'h55, 32'h4000_0000, 8'd1);
    clr = 1'b1; ring = 1'b0; valid = 2'b01; id_in = 16'h0066;
    @(negedge clk);
    clr = 1'b0; valid = '0;
    checkOutput("clear_log_cnt", 128'(log_cnt), 128'd0);
    checkOutput("clear_wr_ptr", 128'(wr_ptr), 128'd0);
    checkOutput("clear_drop", 128'(drop_cnt), 128'd0);
    readEntry(4'd0, rd);
    checkOutput("clear_ram0_kept", 128'(rd), 128'(exp_tab[0]));
    doClear(1'b0);
    applyStimulus(2'b01, 8'h77, 8'h00, 32'h5000_0000, 8'd2);
    idle(1);
    readEntry(4'd0, rd);
    checkOutput("clear_ts_restart", 128'(rd), 128'({32'd0, 1'b0, 8'h77, 8'd2, 32'h5000_0000}));

    $display("[TB] logging disabled with traffic");
    doClear(1'b0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus(2'b11, 8'(k), 8'(k), 32'h6000_0000, 8'd3);
    checkOutput("disabled_log_cnt", 128'(log_cnt), 128'd0);
    checkOutput("disabled_drop", 128'(drop_cnt), 128'd0);
    en = 1'b1;
    applyStimulus(2'b01, 8'h99, 8'h00, 32'h6000_1000, 8'd9);
    idle(1);
    checkOutput("disabled_then_log_cnt", 128'(log_cnt), 128'd1);
    readEntry(4'd0, rd);
    ent = log_entry_t'(rd);
    checkOutput("disabled_ts", 128'(ent.ts), 128'd10);

    $display("[TB] stop mode with 20 events");
    doClear(1'b0);
    ring = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(2'b01, 8'(i), 8'h00, 32'h7000_0000 + 32'(i * 16), 8'(i));
      idle(2);
    end
    idle(2);
    checkOutput("stop_log_cnt", 128'(log_cnt), 128'd16);
    checkOutput("stop_full", 128'(full), 128'd1);
    checkOutput("stop_wr_ptr", 128'(wr_ptr), 128'd0);
    checkOutput("stop_wrapped", 128'(wrapped), 128'd0);
    checkOutput("stop_drop", 128'(drop_cnt), 128'd3);
    readEntry(4'd0, rd);
    checkOutput("stop_ram0", 128'(rd), 128'({32'd0, 1'b0, 8'd1, 8'd1, 32'h7000_0010}));
    readEntry(4'd15, rd);
    checkOutput("stop_ram15", 128'(rd), 128'({32'd45, 1'b0, 8'd16, 8'd16, 32'h7000_0100}));

    $display("[TB] ring mode with 20 events");
    doClear(1'b1);
    ring = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(2'b01, 8'(i), 8'h00, 32'h8000_0000 + 32'(i * 16), 8'(i));
      idle(2);
    end
    idle(2);
    checkOutput("ring_wrapped", 128'(wrapped), 128'd1);
    checkOutput("ring_full", 128'(full), 128'd1);
    checkOutput("ring_wr_ptr", 128'(wr_ptr), 128'd4);
    checkOutput("ring_log_cnt", 128'(log_cnt), 128'd16);
    checkOutput("ring_drop", 128'(drop_cnt), 128'd0);
    exp_tab[0] = {32'd48, 1'b0, 8'd17, 8'd17, 32'h8000_0110};
    exp_tab[1] = {32'd51, 1'b0, 8'd18, 8'd18, 32'h8000_0120};
    exp_tab[2] = {32'd54, 1'b0, 8'd19, 8'd19, 32'h8000_0130};
    exp_tab[3] = {32'd57, 1'b0, 8'd20, 8'd20, 32'h8000_0140};
    for (int a = 0; a < 4; a++) begin
      readEntry(4'(a), rd);
      checkOutput($sformatf("ring_entry%0d", a), 128'(rd), 128'(exp_tab[a]));
    end

    $display("[TB] reset mid-operation");
    ring  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst2_log_cnt", 128'(log_cnt), 128'd0);
    checkOutput("rst2_wrapped", 128'(wrapped), 128'd0);
    checkOutput("rst2_full", 128'(full), 128'd0);
    checkOutput("rst2_rd_data", 128'(rd_data), 128'd0);
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
